// File: rtl/reading_pkg.sv
// reading_pkg: controller states, fail codes, frame field positions and checksum helper
package reading_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        ARM,
        WAIT_DONE,
        CHECK,
        PUBLISH,
        GAP,
        FAIL
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0] CODE_ERROR    = 2'b10;
    localparam logic [1:0] CODE_CHECKSUM = 2'b11;

    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CSUM_LSB     = 0;

    // checksum byte must equal the mod-256 sum of the four data bytes
    function automatic logic checksum_ok(input logic [39:0] f);
        return f[CSUM_LSB +: 8] == f[HUM_INT_LSB +: 8] + f[HUM_DEC_LSB +: 8]
                                 + f[TEMP_INT_LSB +: 8] + f[TEMP_DEC_LSB +: 8];
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for one asynchronous input bit
module sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the input through two flops so the second one settles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) {q, meta} <= 2'b00;
        else          {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/reading_controller.sv
// reading_controller: sequences decoder enable, timeouts, retries and checksum validation of sensor frames
// Optional READING_CONTROLLER_STATS_EN adds saturating good_count/bad_count outputs.
module reading_controller
    import reading_pkg::*;
#(
    parameter int CLOCK_HZ         = 50000000,
    parameter int HOLD_CYCLES      = 1000,
    parameter int TIMEOUT_CYCLES   = 5000000,
    parameter int RETRY_GAP_CYCLES = 50000000,
    parameter int MAX_ATTEMPTS     = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        request,
    input  logic [39:0] sensor_data,
    input  logic        sensor_error,
    input  logic        sensor_done,
    output logic        sensor_enable,
    output logic [7:0]  humidity_int,
    output logic [7:0]  humidity_dec,
    output logic [7:0]  temperature_int,
    output logic [7:0]  temperature_dec,
    output logic        data_valid,
    output logic        busy,
    output logic        fail,
    output logic [1:0]  fail_code
`ifdef READING_CONTROLLER_STATS_EN
    ,
    output logic [7:0]  good_count,
    output logic [7:0]  bad_count
`endif
);

    if (CLOCK_HZ <= 0 || MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 7) begin : g_bad_params
        $error("reading_controller: invalid CLOCK_HZ or MAX_ATTEMPTS");
    end

    state_t      state, next_state;
    logic [31:0] count;
    logic [2:0]  attempts;
    logic [39:0] frame;
    logic        done_s, err_s;
    logic        attempt_fail, last_attempt;
    logic [1:0]  cause;

    sync2 u_done_sync (.clock(clock), .reset_n(reset_n), .d(sensor_done),  .q(done_s));
    sync2 u_err_sync  (.clock(clock), .reset_n(reset_n), .d(sensor_error), .q(err_s));

    assign last_attempt = attempts == 3'(MAX_ATTEMPTS - 1);

    // next state, attempt failure detection and its cause
    always_comb begin
        next_state   = state;
        attempt_fail = 1'b0;
        cause        = CODE_NONE;
        case (state)
            IDLE:      next_state = request ? RELEASE : IDLE;
            RELEASE:   next_state = (count == 32'(HOLD_CYCLES - 1)) ? ARM : RELEASE;
            ARM:       next_state = WAIT_DONE;
            WAIT_DONE: begin
                attempt_fail = (done_s && err_s) || (!done_s && count == 32'(TIMEOUT_CYCLES - 1));
                cause        = done_s ? CODE_ERROR : CODE_TIMEOUT;
                next_state   = done_s ? CHECK : WAIT_DONE;
            end
            CHECK: begin
                attempt_fail = !checksum_ok(frame);
                cause        = CODE_CHECKSUM;
                next_state   = PUBLISH;
            end
            PUBLISH:   next_state = IDLE;
            GAP:       next_state = (count == 32'(RETRY_GAP_CYCLES - 1)) ? RELEASE : GAP;
            FAIL:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (attempt_fail) next_state = last_attempt ? FAIL : GAP;
    end

    // state register, per-state cycle counter and failed-attempt count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            attempts <= '0;
        end else begin
            state    <= next_state;
            count    <= (next_state != state || state == IDLE) ? '0 : count + 32'd1;
            attempts <= (state == IDLE) ? '0 : attempts + {2'b00, attempt_fail};
        end
    end

    // capture the frame on the first synchronized done of an attempt
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) frame <= '0;
        else if (state == WAIT_DONE && done_s) frame <= sensor_data;
    end

    // registered outputs decoded from the upcoming state so they line up with it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sensor_enable   <= 1'b0;
            busy            <= 1'b0;
            data_valid      <= 1'b0;
            fail            <= 1'b0;
            fail_code       <= CODE_NONE;
            humidity_int    <= '0;
            humidity_dec    <= '0;
            temperature_int <= '0;
            temperature_dec <= '0;
        end else begin
            sensor_enable <= next_state inside {ARM, WAIT_DONE, CHECK, PUBLISH};
            busy          <= !(next_state inside {IDLE, PUBLISH, FAIL});
            data_valid    <= next_state == PUBLISH;
            fail          <= next_state == FAIL;
            if (next_state == FAIL) fail_code <= cause;
            if (next_state == PUBLISH) begin
                humidity_int    <= frame[HUM_INT_LSB +: 8];
                humidity_dec    <= frame[HUM_DEC_LSB +: 8];
                temperature_int <= frame[TEMP_INT_LSB +: 8];
                temperature_dec <= frame[TEMP_DEC_LSB +: 8];
            end
        end
    end

`ifdef READING_CONTROLLER_STATS_EN
    // saturating counts of published readings and failed attempts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            good_count <= '0;
            bad_count  <= '0;
        end else begin
            if (next_state == PUBLISH && good_count != 8'hff) good_count <= good_count + 8'd1;
            if (attempt_fail && bad_count != 8'hff) bad_count <= bad_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reading_controller.sv
// tb_reading_controller: randomized decoder scripts checked against an outcome-level reference model
module tb_reading_controller;

    localparam int HOLD = 5, TMO = 60, GAP = 20, MAXA = 3;

    logic        clock = 0, reset_n = 0, request = 0;
    logic [39:0] sensor_data = 0;
    logic        sensor_error = 0, sensor_done = 0;
    logic        sensor_enable, data_valid, busy, fail;
    logic [7:0]  humidity_int, humidity_dec, temperature_int, temperature_dec;
    logic [1:0]  fail_code;
`ifdef READING_CONTROLLER_STATS_EN
    logic [7:0]  good_count, bad_count;
`endif

    int checks = 0, errors = 0;
    int kind [0:7];
    logic [39:0] frm [0:7];
    int dly [0:7];
    int att = 0, cur = 0, cyc = 0, done_cyc = 0, low_len = 0, gap_err = 0, wait_cnt = 0;
    bit active = 0, pending = 0;
    logic [31:0] exp_read = 0;
    logic [1:0]  exp_code = 0;

    reading_controller #(
        .CLOCK_HZ(100), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO),
        .RETRY_GAP_CYCLES(GAP), .MAX_ATTEMPTS(MAXA)
    ) dut (
        .clock(clock), .reset_n(reset_n), .request(request),
        .sensor_data(sensor_data), .sensor_error(sensor_error), .sensor_done(sensor_done),
        .sensor_enable(sensor_enable), .humidity_int(humidity_int), .humidity_dec(humidity_dec),
        .temperature_int(temperature_int), .temperature_dec(temperature_dec),
        .data_valid(data_valid), .busy(busy), .fail(fail), .fail_code(fail_code)
`ifdef READING_CONTROLLER_STATS_EN
        , .good_count(good_count), .bad_count(bad_count)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind 0: valid frame, 1: bad checksum, 2: decoder error, 3: done never rises
    function automatic logic [39:0] mk(input int k);
        logic [7:0] a, b, c, d, s;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        s = a + b + c + d;
        if (k == 1) s = s + 8'($urandom_range(1, 255));
        return {a, b, c, d, s};
    endfunction

    // behavioural decoder: answers each enable rise according to the script
    initial forever begin
        @(negedge clock);
        if (!sensor_enable) begin
            sensor_done = 0; sensor_error = 0; active = 0; pending = 0; low_len++;
        end else if (!active) begin
            if (att > 0 && low_len != HOLD + GAP) gap_err++;
            active = 1; low_len = 0; cur = att % 8; att++;
            pending = kind[cur] != 3; wait_cnt = dly[cur];
        end else if (pending) begin
            if (wait_cnt == 0) begin
                sensor_data = frm[cur]; sensor_error = kind[cur] == 2; sensor_done = 1;
                done_cyc = cyc; pending = 0;
            end else wait_cnt--;
        end
    end

    task automatic run(input string tag, input bit extra);
        int pass_at, exp_att, dv, fl, lat;
        pass_at = -1;
        for (int i = 0; i < MAXA; i++) if (pass_at < 0 && kind[i] == 0) pass_at = i;
        exp_att = pass_at >= 0 ? pass_at + 1 : MAXA;
        if (pass_at >= 0) exp_read = frm[pass_at][39:8];
        else exp_code = kind[MAXA-1] == 1 ? 2'b11 : kind[MAXA-1] == 2 ? 2'b10 : 2'b01;
        @(negedge clock);
        att = 0; gap_err = 0; request = 1;
        @(negedge clock);
        request = 0;
        check({tag, "_busy_set"}, busy, 1);
        dv = 0; fl = 0; lat = -1;
        for (int t = 0; t < 1000 && dv == 0 && fl == 0; t++) begin
            @(negedge clock);
            request = extra && t == 10;
            if (data_valid) begin dv++; lat = cyc - done_cyc; end
            if (fail) fl++;
        end
        request = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (data_valid) dv++;
            if (fail) fl++;
        end
        check({tag, "_dv_count"}, dv, pass_at >= 0 ? 1 : 0);
        check({tag, "_fail_count"}, fl, pass_at >= 0 ? 0 : 1);
        check({tag, "_attempts"}, att, exp_att);
        check({tag, "_gap_len_errs"}, gap_err, 0);
        check({tag, "_busy_clear"}, busy, 0);
        check({tag, "_enable_low"}, sensor_enable, 0);
        check({tag, "_readings"}, {humidity_int, humidity_dec, temperature_int, temperature_dec}, exp_read);
        check({tag, "_fail_code"}, fail_code, exp_code);
        if (pass_at >= 0) check({tag, "_latency"}, lat, 4);
    endtask

    task automatic set_script(input int k0, input int k1, input int k2);
        kind[0] = k0; kind[1] = k1; kind[2] = k2;
        for (int i = 0; i < 3; i++) begin
            frm[i] = mk(kind[i]);
            dly[i] = $urandom_range(0, 8);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_enable"}, sensor_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dv"}, data_valid, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_code"}, fail_code, 0);
        check({tag, "_readings"}, {humidity_int, humidity_dec, temperature_int, temperature_dec}, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin kind[i] = 3; frm[i] = 0; dly[i] = 0; end
        repeat (3) @(negedge clock);
        check_cleared("reset");
        reset_n = 1;

        set_script(0, 0, 0); frm[0] = 40'h3C00190055;
        run("basic", 0);
        set_script(1, 1, 1);
        for (int i = 0; i < 3; i++) frm[i] = 40'h3C00190056;
        run("csum_fail", 0);
        set_script(3, 3, 3);
        run("timeout_fail", 0);
        set_script(2, 0, 0); frm[1] = 40'h2801150947;
        run("err_retry", 0);
        set_script(0, 0, 0);
        run("double_req", 1);

        for (int r = 0; r < 20; r++)
            begin
                set_script($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                run($sformatf("rand%0d", r), r % 4 == 0);
            end

        set_script(3, 3, 3);
        @(negedge clock); att = 0; request = 1;
        @(negedge clock); request = 0;
        repeat (HOLD + 15) @(negedge clock);
        check("mid_enable_high", sensor_enable, 1);
        reset_n = 0;
        #1;
        check_cleared("mid_reset");
        exp_read = 0; exp_code = 0;
        repeat (2) @(negedge clock);
        reset_n = 1;
        set_script(1, 0, 0);
        run("after_reset", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
